axi4_master_tg: RTL and testbench

AXI4 initiator and traffic generator that drives the memory-mapped AXI4 slave through the shared axi4_if channel set. On start it issues one INCR write burst with a seeded incrementing data pattern, then reads the same range back and checks every beat. It reports mismatches and non-OKAY responses in a saturating error counter. It serves as the self-checking initiator for slave bring-up and system-level regression.

---
 rtl/axi4_master_tg_if.sv | 57 +++++
 rtl/axi4_master_tg.sv | 183 ++++++++++++++++++
 tb/tb_axi4_master_tg.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_master_tg_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) shared between the traffic generator and a memory-mapped slave.
// Clock and reset stay outside the bundle as plain ports of each endpoint.
interface axi4_master_tg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_master_tg.sv
// AXI4 traffic generator: writes one INCR burst of seed+i, reads it back and counts bad beats/responses.
// error_cnt saturates and holds its value until the next accepted start.
module axi4_master_tg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ERR_W      = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      error_cnt,
    axi4_master_tg_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [7:0]            idx;
    logic                  aw_done;
    logic                  w_done;

    logic                  aw_valid;
    logic                  w_valid;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] expect_data;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  w_last_hs;
    logic                  b_hs;
    logic                  r_hs;
    logic                  r_bad;
    logic [ERR_W-1:0]      err_inc;

    // One beat index serves both directions: write pattern generation, then read-back comparison.
    assign last_beat   = (idx == len_q);
    assign expect_data = seed_q + DATA_WIDTH'(idx);

    assign aw_valid  = (state == S_WR) && !aw_done;
    assign w_valid   = (state == S_WR) && !w_done;
    assign aw_hs     = aw_valid && bus.AWREADY;
    assign w_hs      = w_valid && bus.WREADY;
    assign w_last_hs = w_hs && last_beat;
    assign b_hs      = (state == S_WRESP) && bus.BVALID;
    assign r_hs      = (state == S_RDATA) && bus.RVALID;

    assign r_bad   = (bus.RDATA != expect_data) || (bus.RRESP != 2'b00) || (bus.RLAST != last_beat);
    assign err_inc = (error_cnt == {ERR_W{1'b1}}) ? error_cnt : error_cnt + ERR_W'(1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // AW and the final W beat may complete in either order or together.
                if ((aw_done || aw_hs) && (w_done || w_last_hs)) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bus.BVALID) begin
                    state_d = S_RADDR;
                end
            end
            S_RADDR: begin
                if (bus.ARREADY) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                // The beat count alone ends the read; a misplaced RLAST is only scored.
                if (r_hs && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.AWADDR  = addr_q;
        bus.AWLEN   = len_q;
        bus.AWVALID = aw_valid;
        bus.WDATA   = expect_data;
        bus.WLAST   = w_valid && last_beat;
        bus.WVALID  = w_valid;
        bus.BREADY  = (state == S_WRESP);
        bus.ARADDR  = addr_q;
        bus.ARLEN   = len_q;
        bus.ARVALID = (state == S_RADDR);
        bus.RREADY  = (state == S_RDATA);
        busy        = (state == S_WR) || (state == S_WRESP) || (state == S_RADDR) || (state == S_RDATA);
        done        = (state == S_DONE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            idx       <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            error_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        len_q     <= len;
                        seed_q    <= seed;
                        idx       <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        error_cnt <= '0;
                    end
                end
                S_WR: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        if (last_beat) begin
                            w_done <= 1'b1;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                S_WRESP: begin
                    idx <= '0;
                    if (b_hs && (bus.BRESP != 2'b00)) begin
                        error_cnt <= err_inc;
                    end
                end
                S_RDATA: begin
                    if (r_hs) begin
                        idx <= idx + 8'd1;
                        if (r_bad) begin
                            error_cnt <= err_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_master_tg.sv
// Bench for axi4_master_tg: behavioural AXI4 memory slave with stall/fault knobs, plus a
// negedge monitor that scores W beats and each done pulse against queued expectations.
module tb_axi4_master_tg;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int EW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    len;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic [EW-1:0] error_cnt;

    axi4_master_tg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi4_master_tg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_W(EW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .error_cnt (error_cnt),
        .bus       (bus)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } wbeat_t;

    typedef struct {
        int err;
        int beats;
    } op_t;

    wbeat_t exp_w[$];
    op_t    exp_d[$];
    int     total = 0;
    int     bad = 0;
    int     done_count = 0;
    int     ops_issued = 0;

    // slave behaviour knobs
    int         aw_stall = 0;
    bit         wready_toggle = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    int         corrupt_beat = -1;
    bit         corrupt_all = 1'b0;
    int         rlast_beat = -1;

    logic [DW-1:0] mem [0:16383];
    logic [DW-1:0] wbuf [0:255];
    int            aw_cnt, wcnt, r_idx, r_len;
    bit            s_aw_got, s_wlast, r_active;
    logic [AW-1:0] s_aw_addr, r_base;
    bit            c_aw_hs, c_aw_stalled, c_w_hs, c_wlast, c_b_hs, c_ar_hs, c_r_hs;
    logic [DW-1:0] c_wdata;
    logic [AW-1:0] c_awaddr, c_araddr;
    logic [7:0]    c_arlen;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a, input int i);
        return (int'(a >> 2) + i) & 16'h3FFF;
    endfunction

    task automatic slave_clear();
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BRESP   = 2'b00;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RDATA   = '0;
        bus.RRESP   = 2'b00;
        bus.RLAST   = 1'b0;
        aw_cnt   = 0;
        wcnt     = 0;
        r_idx    = 0;
        r_len    = 0;
        s_aw_got = 1'b0;
        s_wlast  = 1'b0;
        r_active = 1'b0;
    endtask

    // Slave: sample handshakes at negedge (stable), act on them just after the following posedge.
    initial begin
        slave_clear();
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                slave_clear();
            end else begin
                c_aw_hs      = bus.AWVALID && bus.AWREADY;
                c_aw_stalled = bus.AWVALID && !bus.AWREADY;
                c_w_hs       = bus.WVALID && bus.WREADY;
                c_wlast      = bus.WLAST;
                c_wdata      = bus.WDATA;
                c_awaddr     = bus.AWADDR;
                c_b_hs       = bus.BVALID && bus.BREADY;
                c_ar_hs      = bus.ARVALID && bus.ARREADY;
                c_araddr     = bus.ARADDR;
                c_arlen      = bus.ARLEN;
                c_r_hs       = bus.RVALID && bus.RREADY;
                @(posedge ACLK);
                #1;
                if (!ARESETn) begin
                    slave_clear();
                end else begin
                    if (c_aw_hs) begin
                        s_aw_addr = c_awaddr;
                        s_aw_got  = 1'b1;
                        aw_cnt    = 0;
                    end else if (c_aw_stalled) begin
                        aw_cnt++;
                    end
                    bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_stall);

                    if (c_w_hs && wcnt < 256) begin
                        wbuf[wcnt] = c_wdata;
                        wcnt++;
                        if (c_wlast) s_wlast = 1'b1;
                    end
                    bus.WREADY = wready_toggle ? !bus.WREADY : 1'b1;

                    if (c_b_hs) begin
                        bus.BVALID = 1'b0;
                        s_aw_got   = 1'b0;
                        s_wlast    = 1'b0;
                        wcnt       = 0;
                    end else if (s_aw_got && s_wlast && !bus.BVALID) begin
                        for (int i = 0; i < wcnt; i++) mem[widx(s_aw_addr, i)] = wbuf[i];
                        bus.BVALID = 1'b1;
                        bus.BRESP  = bresp_cfg;
                    end

                    if (c_ar_hs) begin
                        r_active = 1'b1;
                        r_idx    = 0;
                        r_base   = c_araddr;
                        r_len    = int'(c_arlen);
                    end else if (c_r_hs) begin
                        if (r_idx == r_len) r_active = 1'b0;
                        else r_idx++;
                    end
                    bus.ARREADY = bus.ARVALID;

                    bus.RVALID = r_active;
                    bus.RRESP  = 2'b00;
                    if (r_active) begin
                        bus.RDATA = mem[widx(r_base, r_idx)] ^
                                    ((corrupt_all || r_idx == corrupt_beat) ? 32'h0000_0100 : 32'h0);
                        bus.RLAST = (rlast_beat >= 0) ? (r_idx == rlast_beat) : (r_idx == r_len);
                    end else begin
                        bus.RDATA = '0;
                        bus.RLAST = 1'b0;
                    end
                end
            end
        end
    end

    bit            m_aw_stall, m_w_stall, m_aw_seen, m_bready_seen;
    logic [AW-1:0] m_awaddr;
    logic [DW-1:0] m_wdata;
    logic          m_wlast;
    int            m_rcnt;
    wbeat_t        m_beat;
    op_t           m_op;

    // Monitor: protocol stability, W beat scoreboard, and per-operation results at done.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            m_aw_stall    = 1'b0;
            m_w_stall     = 1'b0;
            m_aw_seen     = 1'b0;
            m_bready_seen = 1'b0;
            m_rcnt        = 0;
        end else begin
            if (m_aw_stall) check_output("aw_hold", {bus.AWVALID, bus.AWADDR}, {1'b1, m_awaddr});
            if (m_w_stall) check_output("w_hold", {bus.WVALID, bus.WLAST, bus.WDATA}, {1'b1, m_wlast, m_wdata});
            m_aw_stall = bus.AWVALID && !bus.AWREADY;
            m_awaddr   = bus.AWADDR;
            m_w_stall  = bus.WVALID && !bus.WREADY;
            m_wdata    = bus.WDATA;
            m_wlast    = bus.WLAST;

            if (bus.AWVALID && bus.AWREADY) m_aw_seen = 1'b1;
            if (bus.WVALID && bus.WREADY) begin
                check_output("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    m_beat = exp_w.pop_front();
                    check_output("wdata", bus.WDATA, m_beat.data);
                    check_output("wlast", bus.WLAST, m_beat.last);
                end
            end
            if (bus.BREADY && !m_bready_seen) begin
                check_output("wresp_after_aw", m_aw_seen, 1);
                m_bready_seen = 1'b1;
            end
            if (bus.RVALID && bus.RREADY) m_rcnt++;

            if (done) begin
                check_output("done_expected", exp_d.size() != 0, 1);
                check_output("busy_at_done", busy, 0);
                check_output("w_left", exp_w.size(), 0);
                if (exp_d.size() != 0) begin
                    m_op = exp_d.pop_front();
                    check_output("error_cnt", error_cnt, m_op.err);
                    check_output("r_beats", m_rcnt, m_op.beats);
                end
                done_count++;
                m_aw_seen     = 1'b0;
                m_bready_seen = 1'b0;
                m_rcnt        = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic [AW-1:0] a, input logic [7:0] l,
                                  input logic [DW-1:0] s, input int exp_err);
        wbeat_t b;
        op_t    o;
        for (int i = 0; i <= int'(l); i++) begin
            b.data = s + DW'(i);
            b.last = (i == int'(l));
            exp_w.push_back(b);
        end
        o.err   = exp_err;
        o.beats = int'(l) + 1;
        exp_d.push_back(o);
        @(posedge ACLK);
        #1;
        start     = 1'b1;
        base_addr = a;
        len       = l;
        seed      = s;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        ops_issued++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_count < ops_issued && n < 3000) begin
            @(posedge ACLK);
            n++;
        end
        check_output("done_seen", done_count, ops_issued);
        repeat (4) @(posedge ACLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        bad++;
        total++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        ARESETn   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        seed      = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check_output("rst_busy_done", {busy, done}, 0);
        check_output("rst_error_cnt", error_cnt, 0);
        check_output("rst_valid_ready", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.WLAST}, 0);
        check_output("rst_addr_len", {bus.AWADDR, bus.ARADDR, bus.AWLEN, bus.ARLEN}, 0);
        check_output("rst_wdata", bus.WDATA, 0);
        ARESETn = 1'b1;

        $display("[TB] single beat");
        apply_stimulus(16'h0010, 8'd0, 32'hA5A5_0000, 0);
        wait_done();

        $display("[TB] wrapping pattern");
        apply_stimulus(16'h0100, 8'd3, 32'hFFFF_FFFE, 0);
        wait_done();

        $display("[TB] stalled AW, toggling WREADY");
        aw_stall      = 5;
        wready_toggle = 1'b1;
        apply_stimulus(16'h0200, 8'd3, 32'h1234_5678, 0);
        wait_done();
        aw_stall = 12;
        apply_stimulus(16'h0240, 8'd3, 32'h8765_4321, 0);
        wait_done();
        aw_stall      = 0;
        wready_toggle = 1'b0;

        $display("[TB] error responses");
        bresp_cfg    = 2'b10;
        corrupt_beat = 2;
        apply_stimulus(16'h0300, 8'd3, 32'h00C0_FFEE, 2);
        wait_done();
        rlast_beat = 1;
        apply_stimulus(16'h0300, 8'd3, 32'h00C0_FFEE, 4);
        wait_done();
        rlast_beat   = -1;
        corrupt_beat = -1;

        $display("[TB] error counter saturation");
        corrupt_all = 1'b1;
        apply_stimulus(16'h1000, 8'd255, 32'h0000_1000, 255);
        wait_done();
        corrupt_all = 1'b0;
        bresp_cfg   = 2'b00;

        $display("[TB] reset mid read");
        apply_stimulus(16'h0400, 8'd7, 32'h0000_0055, 0);
        n = 0;
        while (!bus.RREADY && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        check_output("reached_rdata", bus.RREADY, 1);
        repeat (2) @(negedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_output("async_rst_valid_ready", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, 0);
        check_output("async_rst_busy", busy, 0);
        exp_w.delete();
        exp_d.delete();
        ops_issued = done_count;
        repeat (2) @(negedge ACLK);
        #2;
        ARESETn = 1'b1;
        apply_stimulus(16'h0020, 8'd0, 32'h0000_0077, 0);
        wait_done();

        $display("[TB] max burst with ignored start");
        apply_stimulus(16'h0800, 8'd255, 32'hDEAD_0000, 0);
        repeat (10) @(posedge ACLK);
        #1;
        start     = 1'b1;
        base_addr = 16'h0F00;
        len       = 8'd0;
        seed      = 32'h0;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        wait_done();
        check_output("idle_after_max", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
